overcurrent_guard: RTL and testbench
====================================

# overcurrent_guard

Drive-enable fault manager for one motor channel. Consumes the debounced overcurrent bit from the per-channel overcurrent filter and the controller's drive request. Gates the H-bridge/PWM enable with automatic retry after a holdoff. Latches a hard fault after too many consecutive trips. Sits between the filter output and the PWM enable input of the motor driver.

## Interface
Parameters:
- HOLDOFF_CYCLES, 50000: drive-off time after a trip (1 ms at 50 MHz); must be ≥ 2.
- BLANK_CYCLES, 500: inrush window after each enable, during which oc_flt is ignored; must be ≥ 1.
- MAX_RETRY, 3: consecutive trips allowed before lockout; range 1..15.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- oc_flt, in, 1: debounced overcurrent flag, active high, synchronous to clk.
- drive_req, in, 1: controller requests motor drive (level).
- clr_fault, in, 1: single-cycle pulse that clears a latched fault.
- drive_en, out, 1: registered enable to the PWM stage.
- trip_pulse, out, 1: one-cycle pulse on every trip.
- fault_latched, out, 1: high while in LOCKOUT.
- retry_cnt, out, 4: consecutive trips since the last clean stop; saturates at MAX_RETRY.

## Operation
States: IDLE, BLANK, RUN, TRIP, LOCKOUT. The reset state is IDLE.

- IDLE
  - drive_en=0.
  - drive_req=1 → BLANK, timer loaded with BLANK_CYCLES.
  - clr_fault=1 → retry_cnt=0.
- BLANK
  - drive_en=1; oc_flt is ignored.
  - drive_req=0 → IDLE and retry_cnt=0.
  - Timer expiry → RUN.
- RUN
  - drive_en=1.
  - oc_flt=1 → retry_cnt+1 and trip_pulse=1.
    - If the new retry_cnt equals MAX_RETRY → LOCKOUT.
    - Otherwise → TRIP, timer loaded with HOLDOFF_CYCLES.
  - Otherwise, drive_req=0 → IDLE and retry_cnt=0.
- TRIP
  - drive_en=0.
  - At timer expiry:
    - oc_flt=1 → reload HOLDOFF_CYCLES and stay.
    - Otherwise, drive_req=1 → BLANK.
    - Otherwise → IDLE. retry_cnt is kept in this case.
- LOCKOUT
  - drive_en=0 and fault_latched=1.
  - clr_fault=1 → IDLE and retry_cnt=0.
  - drive_req and oc_flt have no effect.
- Priorities and interactions:
  - In RUN, oc_flt has priority over drive_req=0, so a trip is always counted.
  - clr_fault is ignored in BLANK, RUN and TRIP.
- Timer: one down-counter of width $clog2(max(HOLDOFF_CYCLES, BLANK_CYCLES)+1). Expiry is the cycle the count equals 1, so a state lasts exactly N cycles.

## Timing
- Reset values: drive_en=0, trip_pulse=0, fault_latched=0, retry_cnt=0, timer=0, state IDLE.
- All outputs are registered and change only on a rising clk edge, or asynchronously on reset.
- Trip latency: if oc_flt=1 is sampled in RUN at edge k, drive_en=0 and trip_pulse=1 are visible after edge k. Latency is one cycle.
- Enable latency: if drive_req=1 is sampled in IDLE at edge k, drive_en=1 is visible after edge k.
- drive_en stays high for exactly BLANK_CYCLES cycles in BLANK before RUN is entered.
- After a trip at edge k, drive_en is low for exactly HOLDOFF_CYCLES cycles. With drive_req=1 and oc_flt=0, it rises again after edge k+HOLDOFF_CYCLES.
- retry_cnt updates on the same edge as trip_pulse.
- fault_latched rises on the same edge as the final trip_pulse.
- Reset asserted mid-operation forces all outputs low immediately, with no held state.

## Structure
- Shared package oc_guard_pkg holds:
  - the state encoding constants (binary, 3 bits);
  - the retry_cnt width (4).
- Sub-module oc_timer: loadable down-counter.
  - Inputs: load, load_val. Output: expire.
  - Shared by BLANK and TRIP because they are mutually exclusive.
- Everything else is a single always block for the state plus registered outputs.

## Test plan
Run with HOLDOFF_CYCLES=8, BLANK_CYCLES=4, MAX_RETRY=3.

- Reset and start: with rst_n low, all outputs are 0. Release reset, then drive_req=1 → drive_en=1 one edge later; RUN is reached after 4 cycles.
- Blanking: oc_flt=1 during cycles 1–3 of BLANK → no trip_pulse and drive_en stays 1. oc_flt=1 on the first RUN cycle → trip after one edge.
- Retry: a single oc_flt pulse in RUN → trip_pulse, retry_cnt=1, drive_en low for exactly 8 cycles, then BLANK.
- Persistent fault: oc_flt held at 1 through holdoff → holdoff re-arms; drive_en stays 0 until oc_flt clears.
- Lockout: three trips → fault_latched=1 and retry_cnt=3. drive_req toggling has no effect. A clr_fault pulse → IDLE with retry_cnt=0; drive_req=1 then restarts BLANK.
- Async reset during TRIP at timer value 5 → outputs 0 immediately. After release, state is IDLE with retry_cnt=0.

Source files
------------

// File: rtl/oc_guard_pkg.sv
// Shared definitions for the overcurrent guard: FSM state encoding and retry counter width.
package oc_guard_pkg;

   localparam int RETRY_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BLANK   = 3'd1,
      ST_RUN     = 3'd2,
      ST_TRIP    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/oc_timer.sv
// Loadable down-counter shared by the inrush blanking window and the trip holdoff.
module oc_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count;

   // Parks at zero when idle so a stale value can never produce a spurious expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   // Expiry on the count of one makes a state loaded with N last exactly N cycles.
   assign expire = (count == W'(1));

endmodule

// File: rtl/overcurrent_guard.sv
// Drive-enable fault manager: blanks inrush, retries after a holdoff, locks out after repeated trips.
module overcurrent_guard
   import oc_guard_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int MAX_RETRY      = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               oc_flt,
   input  logic               drive_req,
   input  logic               clr_fault,
   output logic               drive_en,
   output logic               trip_pulse,
   output logic               fault_latched,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int TIMER_W = $clog2(max_int(HOLDOFF_CYCLES, BLANK_CYCLES) + 1);
   localparam logic [TIMER_W-1:0] HOLDOFF_VAL = TIMER_W'(HOLDOFF_CYCLES);
   localparam logic [TIMER_W-1:0] BLANK_VAL   = TIMER_W'(BLANK_CYCLES);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

   state_t               state;
   state_t               state_nxt;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_val;
   logic                 timer_expire;
   logic                 trip_nxt;
   logic [RETRY_W-1:0]   retry_nxt;
   logic [RETRY_W-1:0]   retry_inc;
   logic                 drive_en_nxt;
   logic                 fault_nxt;

   oc_timer #(
      .W(TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .expire   (timer_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         drive_en      <= 1'b0;
         trip_pulse    <= 1'b0;
         fault_latched <= 1'b0;
         retry_cnt     <= '0;
      end else begin
         state         <= state_nxt;
         drive_en      <= drive_en_nxt;
         trip_pulse    <= trip_nxt;
         fault_latched <= fault_nxt;
         retry_cnt     <= retry_nxt;
      end
   end

   // In RUN an overcurrent wins over a dropped request so every trip is counted.
   always_comb begin
      state_nxt  = state;
      timer_load = 1'b0;
      timer_val  = BLANK_VAL;
      trip_nxt   = 1'b0;
      retry_nxt  = retry_cnt;
      retry_inc  = (retry_cnt < RETRY_MAX) ? retry_cnt + RETRY_W'(1) : RETRY_MAX;
      case (state)
         ST_IDLE: begin
            if (clr_fault) begin
               retry_nxt = '0;
            end
            if (drive_req) begin
               state_nxt  = ST_BLANK;
               timer_load = 1'b1;
               timer_val  = BLANK_VAL;
            end
         end
         ST_BLANK: begin
            if (!drive_req) begin
               state_nxt = ST_IDLE;
               retry_nxt = '0;
            end else if (timer_expire) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (oc_flt) begin
               trip_nxt  = 1'b1;
               retry_nxt = retry_inc;
               if (retry_inc == RETRY_MAX) begin
                  state_nxt = ST_LOCKOUT;
               end else begin
                  state_nxt  = ST_TRIP;
                  timer_load = 1'b1;
                  timer_val  = HOLDOFF_VAL;
               end
            end else if (!drive_req) begin
               state_nxt = ST_IDLE;
               retry_nxt = '0;
            end
         end
         ST_TRIP: begin
            // A fault still present at the end of holdoff re-arms it rather than retrying.
            if (timer_expire) begin
               if (oc_flt) begin
                  timer_load = 1'b1;
                  timer_val  = HOLDOFF_VAL;
               end else if (drive_req) begin
                  state_nxt  = ST_BLANK;
                  timer_load = 1'b1;
                  timer_val  = BLANK_VAL;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_LOCKOUT: begin
            if (clr_fault) begin
               state_nxt = ST_IDLE;
               retry_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      drive_en_nxt = (state_nxt == ST_BLANK) || (state_nxt == ST_RUN);
      fault_nxt    = (state_nxt == ST_LOCKOUT);
   end

endmodule

// File: tb/tb_overcurrent_guard.sv
// Scoreboard bench for overcurrent_guard: randomized and scenario stimulus against a phase/age reference model.
module tb_overcurrent_guard;

   localparam int HOLD  = 8;
   localparam int BLANK = 4;
   localparam int MAXR  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       oc_flt = 1'b0;
   logic       drive_req = 1'b0;
   logic       clr_fault = 1'b0;
   logic       drive_en;
   logic       trip_pulse;
   logic       fault_latched;
   logic [3:0] retry_cnt;

   typedef struct {
      bit en;
      bit trip;
      bit fault;
      int retry;
   } exp_t;

   typedef enum {M_OFF, M_INRUSH, M_DRIVING, M_COOLDOWN, M_LOCKED} mode_t;

   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   mode_t m_mode = M_OFF;
   int    m_age = 0;
   int    m_trips = 0;

   overcurrent_guard #(
      .HOLDOFF_CYCLES (HOLD),
      .BLANK_CYCLES   (BLANK),
      .MAX_RETRY      (MAXR)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .oc_flt        (oc_flt),
      .drive_req     (drive_req),
      .clr_fault     (clr_fault),
      .drive_en      (drive_en),
      .trip_pulse    (trip_pulse),
      .fault_latched (fault_latched),
      .retry_cnt     (retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: tracks how many cycles have been spent in the current phase.
   function automatic exp_t model_step(input bit req, input bit oc, input bit clr);
      exp_t e;
      bit   tripped = 1'b0;
      case (m_mode)
         M_OFF: begin
            if (clr) m_trips = 0;
            if (req) begin m_mode = M_INRUSH; m_age = 0; end
         end
         M_INRUSH: begin
            if (!req) begin m_mode = M_OFF; m_trips = 0; end
            else if (m_age + 1 == BLANK) m_mode = M_DRIVING;
            else m_age++;
         end
         M_DRIVING: begin
            if (oc) begin
               tripped = 1'b1;
               m_trips++;
               if (m_trips == MAXR) m_mode = M_LOCKED;
               else begin m_mode = M_COOLDOWN; m_age = 0; end
            end else if (!req) begin
               m_mode = M_OFF;
               m_trips = 0;
            end
         end
         M_COOLDOWN: begin
            if (m_age + 1 == HOLD) begin
               if (oc) m_age = 0;
               else if (req) begin m_mode = M_INRUSH; m_age = 0; end
               else m_mode = M_OFF;
            end else begin
               m_age++;
            end
         end
         M_LOCKED: begin
            if (clr) begin m_mode = M_OFF; m_trips = 0; end
         end
         default: m_mode = M_OFF;
      endcase
      e.en    = (m_mode == M_INRUSH) || (m_mode == M_DRIVING);
      e.trip  = tripped;
      e.fault = (m_mode == M_LOCKED);
      e.retry = m_trips;
      return e;
   endfunction

   task automatic apply_stimulus(input bit req, input bit oc, input bit clr);
      @(negedge clk);
      drive_req = req;
      oc_flt    = oc;
      clr_fault = clr;
      exp_q.push_back(model_step(req, oc, clr));
      @(posedge clk);
   endtask

   task automatic check_reset_zero(input string tag);
      check_output({tag, "_drive_en"}, {31'd0, drive_en}, 32'd0);
      check_output({tag, "_trip_pulse"}, {31'd0, trip_pulse}, 32'd0);
      check_output({tag, "_fault_latched"}, {31'd0, fault_latched}, 32'd0);
      check_output({tag, "_retry_cnt"}, {28'd0, retry_cnt}, 32'd0);
   endtask

   // Called right after a stimulus edge; asserts reset mid-cycle and checks outputs drop at once.
   task automatic async_reset(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_zero(tag);
      m_mode  = M_OFF;
      m_age   = 0;
      m_trips = 0;
      drive_req = 1'b0;
      oc_flt    = 1'b0;
      clr_fault = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_output("drive_en", {31'd0, drive_en}, {31'd0, e.en});
         check_output("trip_pulse", {31'd0, trip_pulse}, {31'd0, e.trip});
         check_output("fault_latched", {31'd0, fault_latched}, {31'd0, e.fault});
         check_output("retry_cnt", {28'd0, retry_cnt}, e.retry);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      #2 check_reset_zero("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Start-up and blanking: overcurrent during inrush is ignored.
      apply_stimulus(1, 0, 0);
      repeat (3) apply_stimulus(1, 1, 0);
      apply_stimulus(1, 0, 0);
      apply_stimulus(1, 1, 0);
      repeat (12) apply_stimulus(1, 0, 0);

      // Second trip with the fault held through holdoff, then recovery.
      apply_stimulus(1, 1, 0);
      repeat (12) apply_stimulus(1, 1, 0);
      repeat (12) apply_stimulus(1, 0, 0);

      // Third trip locks out; request toggling has no effect until cleared.
      apply_stimulus(1, 1, 0);
      for (int i = 0; i < 6; i++) apply_stimulus(i[0], i[1], 0);
      apply_stimulus(1, 0, 1);
      repeat (5) apply_stimulus(1, 0, 0);

      // Trip, then reset while the holdoff timer reads 5.
      apply_stimulus(1, 1, 0);
      repeat (3) apply_stimulus(1, 0, 0);
      async_reset("trip_reset");
      apply_stimulus(0, 0, 0);
      apply_stimulus(1, 0, 0);

      // Randomized traffic with occasional mid-run resets.
      for (int i = 0; i < 1500; i++) begin
         apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
         if (i % 400 == 399) async_reset("rand_reset");
      end

      #2;
      check_output("queue_drain", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
